// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, mem_arbiter and the single-port memory.
// The arbiter takes the slave modport; the requester/memory side takes master.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_resp_valid;
    logic [DATA_WIDTH-1:0] if_resp_data;

    logic                  d_req_valid;
    logic                  d_req_ready;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic                  d_we;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_resp_valid;
    logic [DATA_WIDTH-1:0] d_resp_data;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req_valid, if_addr,
        output if_req_ready, if_resp_valid, if_resp_data,
        input  d_req_valid, d_addr, d_we, d_wdata,
        output d_req_ready, d_resp_valid, d_resp_data,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req_valid, if_addr,
        input  if_req_ready, if_resp_valid, if_resp_data,
        output d_req_valid, d_addr, d_we, d_wdata,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch and data-port accesses onto one single-port memory (IDLE/ACCESS/RESP).
// Build option MEM_ARB_DATA_PRIORITY_EN: fixed data-port priority instead of round-robin.

// Per-port response word: loads mem_rdata when this port owns the ACCESS cycle.
module mem_arb_resp #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cap,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] resp_data
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      resp_data <= '0;
        else if (cap) resp_data <= rdata;
    end
endmodule

module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus,
    output logic           busy
);
    localparam int   NUM_PORTS = 2;
    localparam logic PORT_IF   = 1'b0;
    localparam logic PORT_D    = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [DATA_WIDTH-1:0] wdata;
        logic                  owner;
    } req_t;

    state_t state, state_nxt;
    req_t   req_q, win_req;
    logic   grant_if, grant_d, accept;

    logic [NUM_PORTS-1:0]                 cap, resp_vld;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] resp_data;

`ifdef MEM_ARB_DATA_PRIORITY_EN
    // Data port always wins; fetch only gets through when data is quiet.
    always_comb begin
        grant_d  = bus.d_req_valid;
        grant_if = bus.if_req_valid && !bus.d_req_valid;
    end
`else
    logic last_grant;

    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (bus.if_req_valid && bus.d_req_valid) begin
            grant_if = (last_grant == PORT_D);
            grant_d  = !grant_if;
        end else begin
            grant_if = bus.if_req_valid;
            grant_d  = bus.d_req_valid;
        end
    end

    // Reset to DATA so fetch wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last_grant <= PORT_D;
        else if (accept) last_grant <= grant_d ? PORT_D : PORT_IF;
    end
`endif

    assign accept = (state == IDLE) && (grant_if || grant_d);

    // Fetch never writes; it keeps the previous wdata so mem_wdata does not toggle.
    always_comb begin
        if (grant_d) begin
            win_req.addr  = bus.d_addr;
            win_req.we    = bus.d_we;
            win_req.wdata = bus.d_wdata;
            win_req.owner = PORT_D;
        end else begin
            win_req.addr  = bus.if_addr;
            win_req.we    = 1'b0;
            win_req.wdata = req_q.wdata;
            win_req.owner = PORT_IF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         req_q <= '0;
        else if (accept) req_q <= win_req;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; everything keyed on state so reset kills mem_we and resp_valid at once.
    always_comb begin
        busy             = (state != IDLE);
        bus.if_req_ready = (state == IDLE) && grant_if;
        bus.d_req_ready  = (state == IDLE) && grant_d;
        bus.mem_we       = (state == ACCESS) && req_q.we;
        cap              = '0;
        resp_vld         = '0;
        if (state == ACCESS) cap[req_q.owner]      = 1'b1;
        if (state == RESP)   resp_vld[req_q.owner] = 1'b1;
    end

    assign bus.mem_addr  = req_q.addr;
    assign bus.mem_wdata = req_q.wdata;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_resp
        mem_arb_resp #(.DATA_WIDTH(DATA_WIDTH)) u_resp (
            .clk       (clk),
            .rst       (rst),
            .cap       (cap[p]),
            .rdata     (bus.mem_rdata),
            .resp_data (resp_data[p])
        );
    end

    assign bus.if_resp_valid = resp_vld[PORT_IF];
    assign bus.if_resp_data  = resp_data[PORT_IF];
    assign bus.d_resp_valid  = resp_vld[PORT_D];
    assign bus.d_resp_data   = resp_data[PORT_D];
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a 16-word memory, a shadow copy for expectations,
// and a negedge monitor that pushes on handshake and pops on response.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   init_mem;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    logic [31:0] mem [0:15];
    logic [31:0] sh  [0:15];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int k = 0; k < 16; k++) mem[k] <= 32'hA000_0000 + k;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem[bus.mem_addr[3:0]];

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    bit   grants[$];
    int   gcyc[$];
    exp_t e;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("rdy_excl", {63'd0, bus.if_req_ready && bus.d_req_ready}, 64'd0);
`ifdef MEM_ARB_DATA_PRIORITY_EN
            chk("if_rdy_vs_d", {63'd0, bus.if_req_ready && bus.d_req_valid}, 64'd0);
`endif
            if (bus.if_resp_valid) begin
                if (sbq.size() == 0) chk("if_resp_unexp", 64'd1, 64'd0);
                else begin
                    e = sbq.pop_front();
                    chk("if_resp_port", {63'd0, e.port}, 64'd0);
                    chk("if_resp_data", {32'd0, bus.if_resp_data}, {32'd0, e.exp});
                end
            end
            if (bus.d_resp_valid) begin
                if (sbq.size() == 0) chk("d_resp_unexp", 64'd1, 64'd0);
                else begin
                    e = sbq.pop_front();
                    chk("d_resp_port", {63'd0, e.port}, 64'd1);
                    chk("d_resp_data", {32'd0, bus.d_resp_data}, {32'd0, e.exp});
                    if (e.we) sh[e.addr[3:0]] = e.wdata;
                end
            end
            if (bus.if_req_valid && bus.if_req_ready) begin
                sbq.push_back('{1'b0, 1'b0, bus.if_addr, 32'd0, sh[bus.if_addr[3:0]]});
                grants.push_back(1'b0);
                gcyc.push_back(cyc);
            end
            if (bus.d_req_valid && bus.d_req_ready) begin
                sbq.push_back('{1'b1, bus.d_we, bus.d_addr, bus.d_wdata, sh[bus.d_addr[3:0]]});
                grants.push_back(1'b1);
                gcyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clr_sb();
        sbq.delete(); grants.delete(); gcyc.delete();
    endtask

    // Returns in the ACCESS cycle (one step after the handshake edge).
    task automatic req(input bit port, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, output int waited);
        bit got = 0;
        waited = 0;
        if (port) begin
            bus.d_addr = a; bus.d_we = we; bus.d_wdata = wd; bus.d_req_valid = 1'b1;
        end else begin
            bus.if_addr = a; bus.if_req_valid = 1'b1;
        end
        for (int n = 0; n < 20 && !got; n++) begin
            #1;
            if (port ? bus.d_req_ready : bus.if_req_ready) got = 1;
            else waited++;
            @(posedge clk); #1;
        end
        bus.if_req_valid = 1'b0;
        bus.d_req_valid  = 1'b0;
        bus.d_we         = 1'b0;
        chk("req_timeout", {63'd0, got}, 64'd1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 20 && busy; n++) tick();
        chk("idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    int  w;
    bit  exp_port;

    initial begin
        for (int k = 0; k < 16; k++) sh[k] = 32'hA000_0000 + k;
        init_mem = 1'b1;
        rst = 1'b1;
        bus.if_req_valid = 1'b0; bus.if_addr = '0;
        bus.d_req_valid  = 1'b0; bus.d_addr  = '0; bus.d_we = 1'b0; bus.d_wdata = '0;

        // Reset values, and ready still follows IDLE rules under reset.
        #1;
        chk("rst_busy",    {63'd0, busy}, 64'd0);
        chk("rst_mem_we",  {63'd0, bus.mem_we}, 64'd0);
        chk("rst_mem_addr", {32'd0, bus.mem_addr}, 64'd0);
        chk("rst_mem_wdata", {32'd0, bus.mem_wdata}, 64'd0);
        chk("rst_resp_vld", {62'd0, bus.if_resp_valid, bus.d_resp_valid}, 64'd0);
        chk("rst_if_data", {32'd0, bus.if_resp_data}, 64'd0);
        chk("rst_d_data",  {32'd0, bus.d_resp_data}, 64'd0);
        bus.if_req_valid = 1'b1;
        #1;
        chk("rst_if_rdy", {62'd0, bus.if_req_ready, bus.d_req_ready}, 64'd2);
        bus.if_req_valid = 1'b0;
        tick();
        init_mem = 1'b0;
        tick();
        rst = 1'b0;

        // Single fetch
        req(1'b0, 1'b0, 32'd2, 32'd0, w);
        chk("fetch_rdy_c0", w, 64'd0);
        chk("fetch_busy1", {63'd0, busy}, 64'd1);
        chk("fetch_mem_addr", {32'd0, bus.mem_addr}, 64'd2);
        chk("fetch_mem_we", {63'd0, bus.mem_we}, 64'd0);
        tick();
        chk("fetch_busy2", {63'd0, busy}, 64'd1);
        chk("fetch_resp_vld", {63'd0, bus.if_resp_valid}, 64'd1);
        chk("fetch_resp_data", {32'd0, bus.if_resp_data}, 64'hA000_0002);
        tick();
        chk("fetch_busy3", {63'd0, busy}, 64'd0);

        // Store then load of the same word
        req(1'b1, 1'b1, 32'd3, 32'hDEAD_BEEF, w);
        chk("st_mem_we", {63'd0, bus.mem_we}, 64'd1);
        chk("st_mem_addr", {32'd0, bus.mem_addr}, 64'd3);
        chk("st_mem_wdata", {32'd0, bus.mem_wdata}, 64'hDEAD_BEEF);
        tick();
        chk("st_mem_we_off", {63'd0, bus.mem_we}, 64'd0);
        chk("st_resp_data", {32'd0, bus.d_resp_data}, 64'hA000_0003);
        wait_idle();
        req(1'b1, 1'b0, 32'd3, 32'd0, w);
        wait_idle();
        tick();
        chk("ld_resp_data", {32'd0, bus.d_resp_data}, 64'hDEAD_BEEF);

        // Contention from reset, both ports held valid
        rst = 1'b1;
        #1;
        clr_sb();
        bus.if_addr = 32'd0; bus.if_req_valid = 1'b1;
        bus.d_addr = 32'd1; bus.d_we = 1'b0; bus.d_req_valid = 1'b1;
        tick();
        rst = 1'b0;
        repeat (12) tick();
        bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0;
        repeat (6) tick();
        chk("cont_grants", grants.size(), 64'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
`ifdef MEM_ARB_DATA_PRIORITY_EN
            exp_port = 1'b1;
`else
            exp_port = i[0];
`endif
            chk($sformatf("cont_order%0d", i), {63'd0, grants[i]}, {63'd0, exp_port});
            if (i > 0) chk($sformatf("cont_gap%0d", i), gcyc[i] - gcyc[i-1], 64'd3);
        end
        chk("cont_sb_empty", sbq.size(), 64'd0);

        // Reset in the middle of a store's ACCESS cycle
        req(1'b1, 1'b1, 32'd1, 32'h1234_5678, w);
        chk("abort_we_pre", {63'd0, bus.mem_we}, 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_we_drop", {63'd0, bus.mem_we}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_resp", {63'd0, bus.d_resp_valid}, 64'd0);
        clr_sb();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("abort_mem1", {32'd0, mem[1]}, 64'hA000_0001);
        req(1'b1, 1'b0, 32'd1, 32'd0, w);
        wait_idle();

        // Data request withdrawn while a fetch is in ACCESS
        req(1'b0, 1'b0, 32'd5, 32'd0, w);
        bus.d_addr = 32'd6; bus.d_we = 1'b1; bus.d_wdata = 32'h0000_0BAD; bus.d_req_valid = 1'b1;
        #1;
        chk("wd_d_rdy", {63'd0, bus.d_req_ready}, 64'd0);
        tick();
        bus.d_req_valid = 1'b0; bus.d_we = 1'b0;
        wait_idle();
        repeat (3) tick();
        chk("wd_idle", {63'd0, busy}, 64'd0);
        chk("wd_mem6", {32'd0, mem[6]}, 64'hA000_0006);
        chk("wd_d_hold", {32'd0, bus.d_resp_data}, 64'hA000_0001);

        // All-ones address passes through untouched
        req(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, w);
        chk("max_mem_addr", {32'd0, bus.mem_addr}, 64'hFFFF_FFFF);
        wait_idle();
        tick();
        chk("max_if_data", {32'd0, bus.if_resp_data}, 64'hA000_000F);

        chk("sb_empty", sbq.size(), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
